// File: rtl/fu_issue_fifo.sv
// fu_issue_fifo: per-functional-unit issue queue between issue_logic and one FU.
// Buffers up to DEPTH issue packets in order. It presents the oldest packet to
// the FU with a valid/ready handshake and exports its occupancy so that the
// issue selector can throttle. A single-cycle squash is supported for branch
// mispredicts.
//
// Packet layout (issue_packet_t, flattened to PKT_W bits):
//   [PKT_W-1]   valid   -- forced to deq_valid_o on the dequeue side
//   [PKT_W-2:0] payload -- rob_idx and operands, opaque to this block
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enq_valid_i       issue_logic presents enq_pkt_i this cycle
//   enq_pkt_i         packet from issue_logic
//   enq_ready_o       FIFO accepts a packet this cycle (not full, no flush)
//   deq_valid_o       head entry is valid
//   deq_pkt_o         head packet to the FU
//   deq_ready_i       FU consumes the head this cycle
//   flush_i           squash every buffered packet on the next edge
//   free_slots_o      DEPTH minus occupancy
//   full_o, empty_o   occupancy == DEPTH / occupancy == 0
//   stall_cnt_o       saturating count of cycles with valid head and no ready
module fu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int PKT_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_valid_i,
  input  logic [PKT_W-1:0] enq_pkt_i,
  output logic             enq_ready_o,
  output logic             deq_valid_o,
  output logic [PKT_W-1:0] deq_pkt_o,
  input  logic             deq_ready_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] free_slots_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [31:0]      stall_cnt_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic enq_fire;
  logic deq_fire;

  // enq_ready_o depends only on registered count and flush_i. A full FIFO
  // therefore refuses a packet even when the head leaves in the same cycle.
  assign enq_ready_o  = (count < DEPTH_C) && !flush_i;
  assign deq_valid_o  = (count != '0);
  assign free_slots_o = DEPTH_C - count;
  assign full_o       = (count == DEPTH_C);
  assign empty_o      = (count == '0);

  assign enq_fire = enq_valid_i && enq_ready_o;
  assign deq_fire = deq_valid_o && deq_ready_i && !flush_i;

  // Stale entries remain in mem after a drain or a flush. Overriding the
  // valid bit stops the FU from acting on them.
  always_comb begin
    deq_pkt_o          = mem[head];
    deq_pkt_o[PKT_W-1] = deq_valid_o;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) begin
        mem[tail] <= enq_pkt_i;
        tail      <= (tail == LAST_C) ? '0 : tail + 1'b1;
      end
      if (deq_fire) begin
        head <= (head == LAST_C) ? '0 : head + 1'b1;
      end
      if (enq_fire && !deq_fire) begin
        count <= count + 1'b1;
      end else if (deq_fire && !enq_fire) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_o <= '0;
    end else if (deq_valid_o && !deq_ready_i && !flush_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule
